// File: rtl/izh_neuron_array.sv
// izh_neuron_array
//   Time-multiplexed array of N Izhikevich neurons sharing one fixed-point
//   datapath. A step request walks the neurons in index order, one per clock,
//   and publishes the spike flags once the last neuron is updated.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   step       one-cycle request to advance every neuron by one time step
//   i_flat     packed signed input currents, neuron k at [k*W +: W]
//   cfg_we     configuration write strobe (honoured only while idle)
//   cfg_idx    neuron targeted by the write
//   cfg_sel    0=a 1=b 2=c 3=d 4=p(global) 5=v 6=u 7=no effect
//   cfg_data   signed write data
//   rd_idx     neuron observed on v_out/u_out
//   v_out      v of neuron rd_idx (combinational)
//   u_out      u of neuron rd_idx (combinational)
//   busy       high while a step is in progress
//   done       one-cycle pulse when a step completes
//   spike_vec  spike flags from the last completed step
//
// state | meaning
// IDLE  | waiting for step; configuration writes accepted
// CALC  | updating neuron idx_r this cycle; last neuron returns to IDLE
module izh_neuron_array #(
    parameter int W        = 20,
    parameter int FRAC     = 16,
    parameter int N        = 4,
    parameter int DT_SHIFT = 4,
    parameter int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic [N*W-1:0]      i_flat,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_idx,
    input  logic [2:0]          cfg_sel,
    input  logic signed [W-1:0] cfg_data,
    input  logic [IW-1:0]       rd_idx,
    output logic [W-1:0]        v_out,
    output logic [W-1:0]        u_out,
    output logic                busy,
    output logic                done,
    output logic [N-1:0]        spike_vec
);

    // Round-to-nearest conversion of a value given in thousandths.
    function automatic logic signed [W-1:0] q_milli(input longint milli);
        longint scaled;
        longint r;
        scaled = milli * (longint'(1) <<< FRAC);
        if (scaled >= 0) r = (scaled + 500) / 1000;
        else             r = -((-scaled + 500) / 1000);
        return W'(r);
    endfunction

    localparam logic signed [W-1:0] V_RST = q_milli(-700);
    localparam logic signed [W-1:0] U_RST = q_milli(-200);
    localparam logic signed [W-1:0] A_RST = q_milli(20);
    localparam logic signed [W-1:0] B_RST = q_milli(200);
    localparam logic signed [W-1:0] C_RST = q_milli(-650);
    localparam logic signed [W-1:0] D_RST = q_milli(80);
    localparam logic signed [W-1:0] P_RST = q_milli(300);
    localparam logic signed [W-1:0] C14   = q_milli(1400);

    localparam logic signed [W-1:0]   MAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   MIN_W = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W+1:0]   MAX_A = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0]   MIN_A = {3'b111, {(W-1){1'b0}}};
    localparam logic signed [2*W-1:0] MAX_M = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] MIN_M = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    localparam int             DV_SHIFT = DT_SHIFT - 2;
    localparam logic [IW-1:0]  LAST     = IW'(N - 1);
    localparam logic [IW:0]    N_L      = (IW + 1)'(N);

    function automatic logic signed [W-1:0] sat_a(input logic signed [W+1:0] x);
        if (x > MAX_A) return MAX_W;
        if (x < MIN_A) return MIN_W;
        return x[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] sadd(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
        logic signed [W+1:0] s;
        s = (W+2)'(x) + (W+2)'(y);
        return sat_a(s);
    endfunction

    function automatic logic signed [W-1:0] ssub(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
        logic signed [W+1:0] s;
        s = (W+2)'(x) - (W+2)'(y);
        return sat_a(s);
    endfunction

    // Full-width product rescaled by FRAC; a zero operand gives an exact zero.
    function automatic logic signed [W-1:0] smul(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
        logic signed [2*W-1:0] p;
        logic signed [2*W-1:0] sh;
        p  = (2*W)'(x) * (2*W)'(y);
        sh = p >>> FRAC;
        if (sh > MAX_M) return MAX_W;
        if (sh < MIN_M) return MIN_W;
        return sh[W-1:0];
    endfunction

    // |x| with the most-negative code folded onto the most-positive one.
    function automatic logic signed [W-1:0] sabs(input logic signed [W-1:0] x);
        if (x == MIN_W) return MAX_W;
        if (x[W-1])     return -x;
        return x;
    endfunction

    typedef enum logic {IDLE, CALC} state_t;

    state_t state, state_nxt;
    logic   start, last;

    logic signed [W-1:0] v_r [N];
    logic signed [W-1:0] u_r [N];
    logic signed [W-1:0] a_r [N];
    logic signed [W-1:0] b_r [N];
    logic signed [W-1:0] c_r [N];
    logic signed [W-1:0] d_r [N];
    logic signed [W-1:0] p_r;
    logic [IW-1:0]       idx_r;
    logic [N-1:0]        spk_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        start     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (step) begin
                    start     = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (idx_r == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic cfg_ok;
    assign cfg_ok = cfg_we && (state == IDLE) && ({1'b0, cfg_idx} < N_L);

    logic signed [W-1:0] vk, uk, ak, bk, ck, dk, ik, i_abs;
    logic signed [W-1:0] t_vv, t_s1, t_s2, t_s3, t_s4, t_s5, v_upd;
    logic signed [W-1:0] t_bv, t_bvu, t_abvu, u_upd;
    logic signed [W-1:0] v_nxt, u_nxt;
    logic                fire;
    logic [N-1:0]        spk_nxt;

    always_comb begin
        vk    = v_r[idx_r];
        uk    = u_r[idx_r];
        ak    = a_r[idx_r];
        bk    = b_r[idx_r];
        ck    = c_r[idx_r];
        dk    = d_r[idx_r];
        ik    = i_flat[int'(idx_r)*W +: W];
        i_abs = sabs(ik);

        t_vv  = smul(vk, vk);
        t_s1  = sadd(t_vv, vk);
        t_s2  = sadd(t_s1, vk >>> 2);
        t_s3  = sadd(t_s2, C14 >>> 2);
        t_s4  = ssub(t_s3, uk >>> 2);
        t_s5  = sadd(t_s4, i_abs >>> 2);
        v_upd = sadd(vk, t_s5 >>> DV_SHIFT);

        t_bv   = smul(bk, vk);
        t_bvu  = ssub(t_bv, uk);
        t_abvu = smul(ak, t_bvu);
        u_upd  = sadd(uk, t_abvu >>> DT_SHIFT);

        fire = (vk > p_r);
        if (fire) begin
            v_nxt = ck;
            u_nxt = sadd(uk, dk);
        end else begin
            v_nxt = v_upd;
            u_nxt = u_upd;
        end

        spk_nxt        = spk_acc;
        spk_nxt[idx_r] = fire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                v_r[k] <= V_RST;
                u_r[k] <= U_RST;
                a_r[k] <= A_RST;
                b_r[k] <= B_RST;
                c_r[k] <= C_RST;
                d_r[k] <= D_RST;
            end
            p_r       <= P_RST;
            idx_r     <= '0;
            spk_acc   <= '0;
            spike_vec <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cfg_ok) begin
                case (cfg_sel)
                    3'd0:    a_r[cfg_idx] <= cfg_data;
                    3'd1:    b_r[cfg_idx] <= cfg_data;
                    3'd2:    c_r[cfg_idx] <= cfg_data;
                    3'd3:    d_r[cfg_idx] <= cfg_data;
                    3'd4:    p_r          <= cfg_data;
                    3'd5:    v_r[cfg_idx] <= cfg_data;
                    3'd6:    u_r[cfg_idx] <= cfg_data;
                    default: ;
                endcase
            end
            if (start) begin
                idx_r   <= '0;
                spk_acc <= '0;
            end
            if (busy) begin
                v_r[idx_r] <= v_nxt;
                u_r[idx_r] <= u_nxt;
                spk_acc    <= spk_nxt;
                if (last) begin
                    idx_r     <= '0;
                    spike_vec <= spk_nxt;
                    done      <= 1'b1;
                end else begin
                    idx_r <= idx_r + IW'(1);
                end
            end
        end
    end

    logic rd_ok;
    assign rd_ok = ({1'b0, rd_idx} < N_L);
    assign v_out = rd_ok ? v_r[rd_idx] : '0;
    assign u_out = rd_ok ? u_r[rd_idx] : '0;

endmodule

// File: doc/izh_neuron_array.md
IZH_NEURON_ARRAY -- requirements
Module: izh_neuron_array

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; reset asserts immediately, regardless of clk, and releases synchronously to the next rising clk edge.
REQ-002 Parameter W, default 20: signed fixed-point word width.
REQ-003 Parameter FRAC, default 16: fractional bits, giving Q(W-FRAC).FRAC format.
REQ-004 Parameter N, default 4: neuron count, N≥1; IW = max(1, clog2(N)).
REQ-005 Parameter DT_SHIFT, default 4: dt = 2^-DT_SHIFT.
REQ-006 Port clk, input, 1 bit: clock, rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-008 Port step, input, 1 bit: single-cycle request to advance all neurons by one time step.
REQ-009 Port i_flat, input, N*W bits: signed input current; neuron k uses bits [k*W +: W].
REQ-010 Port cfg_we, input, 1 bit: configuration write strobe.
REQ-011 Port cfg_idx, input, IW bits: neuron index for the write.
REQ-012 Port cfg_sel, input, 3 bits: register select; 0=a, 1=b, 2=c, 3=d, 4=p (global), 5=v, 6=u, 7=reserved (no effect).
REQ-013 Port cfg_data, input, W bits: signed write data.
REQ-014 Port rd_idx, input, IW bits: neuron to observe.
REQ-015 Port v_out, output, W bits: v of neuron rd_idx, combinational from the state store.
REQ-016 Port u_out, output, W bits: u of neuron rd_idx, combinational from the state store.
REQ-017 Port busy, output, 1 bit: high while a step is in progress.
REQ-018 Port done, output, 1 bit: one-cycle pulse when a step completes.
REQ-019 Port spike_vec, output, N bits: per-neuron spike flags from the last completed step.

Function
REQ-020 The FSM SHALL have two states, IDLE and CALC; step in IDLE at edge t enters CALC; neuron k SHALL be updated at edge t+1+k; at edge t+N the block SHALL return to IDLE, done=1 for one cycle and spike_vec SHALL update; busy SHALL be high during cycles t+1..t+N.
REQ-021 step asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-022 i_flat SHALL be sampled per neuron in the neuron's own update cycle.
REQ-023 Spike rule: if v>p (signed compare), then v←c, u←sat(u+d), spike bit k=1.
REQ-024 Otherwise, with I=|i| and |most-negative| saturating to max positive: v←v+((v·v + v + (v>>>2) + (C14>>>2) − (u>>>2) + (I>>>2)) >>> (DT_SHIFT−2)), and spike bit k=0.
REQ-025 Otherwise also: u←u+((a·(b·v−u)) >>> DT_SHIFT).
REQ-026 C14 SHALL be 1.4 in Q format.
REQ-027 Multiply SHALL form a full 2W-bit signed product, shift arithmetically right by FRAC, and saturate to W bits; a zero operand SHALL yield exactly 0.
REQ-028 Every add/subtract SHALL be computed W+2 wide and saturated to W bits; >>> SHALL be arithmetic.
REQ-029 cfg_we in IDLE SHALL write at the next edge; cfg_we while busy, or with cfg_idx≥N, SHALL be ignored.
REQ-030 cfg_we coincident with an accepted step SHALL take effect first; step then uses the new value.

Reset
REQ-031 While reset=0: busy=0, done=0, spike_vec=0, state=IDLE.
REQ-032 Per-neuron reset values: v=−0.7, u=−0.2, a=0.02, b=0.2, c=−0.65, d=0.08.
REQ-033 Global reset values: p=0.30.
REQ-034 Reset values SHALL be rounded to nearest; for W=20/FRAC=16: v=0xF4CCD, u=0xFCCCD, a=0x0051F, b=0x03333, c=0xF599A, d=0x0147B, p=0x04CCD, C14=0x16666.
REQ-035 Reset asserted mid-CALC SHALL abort the step with no done pulse and restore all reset values.

Verification
REQ-036 Release reset, rd_idx=0 -> v_out=0xF4CCD, u_out=0xFCCCD, busy=0, spike_vec=0.
REQ-037 step pulse at edge t, N=4 -> busy high cycles t+1..t+4; done=1 only in cycle t+4 (after edge t+4); state change matches a bit-exact reference model.
REQ-038 cfg write sel=5, idx=2, data=0x50000; then step -> spike_vec=4'b0100; neuron 2 v=0xF599A, u=0xFE148; other neurons follow REQ-024/025.
REQ-039 Second step and a cfg_we at cycle t+2 of a step -> step ignored (single done pulse), cfg register unchanged.
REQ-040 i for neuron 1 = 0x80000 vs 0x7FFFF -> identical v update for neuron 1 (abs saturation).
REQ-041 reset low at cycle t+2 of a step -> outputs immediately at reset values; no done pulse; the next step after release behaves as REQ-037.
